instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Fetch stage of the MIPS core: holds the program counter, drives the byte address into the combinational program memory, and captures the returned word into an IF/ID pipeline register for the decoder. It sits directly upstream of the program memory (address side) and directly downstream of it (instruction side). It supports decode back-pressure, control-flow redirect from execute, optional MIPS branch-delay-slot semantics, and halt.

## Interface
- RESET_PC, 32'h0000_0000: byte address of the first fetch.
- DATA_WIDTH, 32: instruction and address width.
- COUNT_WIDTH, 16: width of the fetch counter.

Ports:
- clk  in  1: single clock, rising edge.
- reset  in  1: synchronous, active-high.
- imem_address  out  DATA_WIDTH: byte address to program memory; equals pc.
- imem_instruction  in  DATA_WIDTH: word read combinationally at imem_address.
- redirect_valid  in  1: taken branch or jump from execute, one-cycle pulse.
- redirect_pc  in  DATA_WIDTH: redirect target byte address.
- halt_req  in  1: stop fetching permanently until reset.
- id_ready  in  1: decode accepts IF/ID this cycle.
- id_valid  out  1: IF/ID holds a valid instruction.
- id_instruction  out  DATA_WIDTH: captured instruction.
- id_pc  out  DATA_WIDTH: address of id_instruction.
- id_pc_plus4  out  DATA_WIDTH: id_pc + 4.
- fetch_misaligned  out  1: sticky; a redirect target had bits [1:0] nonzero.
- fetch_count  out  COUNT_WIDTH: number of IF/ID loads, saturating.

## Operation
- State machine: RUN, SLOT_PENDING (only with the macro), HALTED.
- Load condition: `load = (state != HALTED) && (!id_valid || id_ready)`.
- RUN, no redirect: on load, IF/ID <= {imem_instruction, pc, pc+4}, id_valid <= 1, pc <= pc+4. Without load, pc and IF/ID hold. If id_valid && id_ready && no load (HALTED only), id_valid <= 0.
- Redirect without the macro: pc <= {redirect_pc[31:2], 2'b00}. IF/ID is flushed (id_valid <= 0) regardless of id_ready. The word at the old pc is discarded.
- Redirect with the macro, load true: the delay-slot word at the current pc is loaded into IF/ID, and pc <= target.
- Redirect with the macro, load false: the target is latched in a pending register and the state goes to SLOT_PENDING. The next load captures the slot word, sets pc <= pending target, and the state returns to RUN.
- A second redirect_valid while in SLOT_PENDING is ignored.
- Misaligned target: bits [1:0] are forced to 0 and fetch_misaligned is set. It clears only on reset.
- halt_req: state <= HALTED. halt_req wins over a simultaneous redirect, which is dropped.
- In HALTED, pc is frozen, no loads occur, and a valid IF/ID entry drains on id_ready.
- pc arithmetic wraps modulo 2^32.
- fetch_count increments on each load and sticks at all ones.

## Timing
- Reset values: pc = RESET_PC, state = RUN, id_valid = 0, id_instruction = 0, id_pc = 0, id_pc_plus4 = 0, fetch_misaligned = 0, fetch_count = 0.
- imem_address is the registered pc, with no combinational path from any input.
- Latency: the word at pc appears on id_* on the edge after pc is presented. In the first cycle after reset, id_valid = 0; id_pc = RESET_PC one edge later.
- Free-running throughput is one instruction per cycle.
- A redirect without the macro produces exactly one bubble. With the macro it produces zero bubbles when not stalled.
- Asserting reset mid-stall, mid-SLOT_PENDING, or while HALTED returns the block to reset values on that edge.
- id_* outputs are stable while id_valid && !id_ready.

## Configuration
- BRANCH_DELAY_SLOT_EN defined: architectural delay slot. The instruction after a branch is always delivered, using the SLOT_PENDING state and pending-target register.
- BRANCH_DELAY_SLOT_EN undefined: redirect flushes IF/ID, and SLOT_PENDING and the pending register are not built.

## Structure
- Package mips_fetch_pkg holds:
  - fetch_state_t (RUN, SLOT_PENDING, HALTED);
  - the PC_STEP = 4 constant;
  - the NOP_WORD = 32'h0000_0000 constant used as the reset/flush value of id_instruction.
- One sub-module, if_id_register, holds the IF/ID pipeline register with load, flush, and valid handling. The PC, FSM, and counter stay in the top module.

## Test plan
- Reset release with program memory words 0x20080005, 0x20090003, … → id_pc sequence 0x0, 0x4, 0x8 on consecutive cycles with the matching words; fetch_count = 3 after three loads.
- Hold id_ready = 0 for 3 cycles at id_pc = 0x8 → id_* unchanged and imem_address held at 0xC; on release, id_pc = 0xC on the next edge.
- Macro off, redirect to 0x40 while pc = 0x10 → id_valid = 0 for one cycle, then id_pc = 0x40 and id_pc_plus4 = 0x44.
- Macro on, same stimulus → id_pc = 0x10 (the slot word), then 0x40. Repeat with id_ready = 0 during the redirect: the state goes to SLOT_PENDING, then the same sequence follows after release.
- Redirect to 0x42 → id_pc = 0x40 and fetch_misaligned = 1 until reset.
- halt_req together with redirect → pc frozen, redirect ignored, id_valid drops after one id_ready. With COUNT_WIDTH = 4 and 20 loads, fetch_count = 0xF.

Source files
------------

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch stage.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    StRun         = 2'd0,
    StSlotPending = 2'd1,
    StHalted      = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_STEP  = 4;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: load, flush to NOP and drain-on-ready valid handling.
module if_id_register
  import mips_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic                  flush_i,
  input  logic                  ready_i,
  input  logic [DATA_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic [DATA_WIDTH-1:0] pc_plus4_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic [DATA_WIDTH-1:0] pc_plus4_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] pc_plus4_q, pc_plus4_d;

  always_comb begin
    valid_d    = valid_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    pc_plus4_d = pc_plus4_q;
    if (flush_i) begin
      valid_d = 1'b0;
      instr_d = DATA_WIDTH'(NOP_WORD);
    end else if (load_i) begin
      valid_d    = 1'b1;
      instr_d    = instr_i;
      pc_d       = pc_i;
      pc_plus4_d = pc_plus4_i;
    end else if (ready_i) begin
      // Consumed with nothing to replace it (only reachable while halted).
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q    <= 1'b0;
      instr_q    <= DATA_WIDTH'(NOP_WORD);
      pc_q       <= '0;
      pc_plus4_q <= '0;
    end else begin
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      pc_plus4_q <= pc_plus4_d;
    end
  end

  assign valid_o    = valid_q;
  assign instr_o    = instr_q;
  assign pc_o       = pc_q;
  assign pc_plus4_o = pc_plus4_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: PC, fetch FSM, saturating fetch counter and IF/ID register.
// Define BRANCH_DELAY_SLOT_EN for architectural delay-slot redirects; otherwise redirects flush.
module instruction_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int unsigned                  DATA_WIDTH  = 32,
  parameter logic        [DATA_WIDTH-1:0] RESET_PC    = '0,
  parameter int unsigned                  COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic [DATA_WIDTH-1:0]  imem_address,
  input  logic [DATA_WIDTH-1:0]  imem_instruction,
  input  logic                   redirect_valid,
  input  logic [DATA_WIDTH-1:0]  redirect_pc,
  input  logic                   halt_req,
  input  logic                   id_ready,
  output logic                   id_valid,
  output logic [DATA_WIDTH-1:0]  id_instruction,
  output logic [DATA_WIDTH-1:0]  id_pc,
  output logic [DATA_WIDTH-1:0]  id_pc_plus4,
  output logic                   fetch_misaligned,
  output logic [COUNT_WIDTH-1:0] fetch_count
);

  fetch_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0]  pc_q, pc_d;
  logic [DATA_WIDTH-1:0]  pc_plus4;
  logic [DATA_WIDTH-1:0]  target;
  logic                   load;
  logic                   capture;
  logic                   flush;
  logic                   redirect_take;
  logic                   misaligned_q, misaligned_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
`ifdef BRANCH_DELAY_SLOT_EN
  logic [DATA_WIDTH-1:0]  pend_q, pend_d;
`endif

  assign pc_plus4 = pc_q + DATA_WIDTH'(PC_STEP);
  assign target   = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
  assign load     = (state_q != StHalted) && (!id_valid || id_ready);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    capture       = 1'b0;
    flush         = 1'b0;
    redirect_take = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    pend_d        = pend_q;
`endif
    case (state_q)
      StRun: begin
        if (load) begin
          capture = 1'b1;
          pc_d    = pc_plus4;
        end
        // Halt has priority; a simultaneous redirect is dropped.
        if (halt_req) begin
          state_d = StHalted;
        end else if (redirect_valid) begin
          redirect_take = 1'b1;
`ifdef BRANCH_DELAY_SLOT_EN
          if (load) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            state_d = StSlotPending;
          end
`else
          capture = 1'b0;
          flush   = 1'b1;
          pc_d    = target;
`endif
        end
      end
`ifdef BRANCH_DELAY_SLOT_EN
      StSlotPending: begin
        if (load) begin
          capture = 1'b1;
          pc_d    = pend_q;
          state_d = StRun;
        end
        if (halt_req) state_d = StHalted;
      end
`endif
      StHalted: state_d = StHalted;
      default:  state_d = StRun;
    endcase
  end

  assign misaligned_d = misaligned_q | (redirect_take & (|redirect_pc[1:0]));
  assign count_d      = (capture && (count_q != '1)) ? count_q + 1'b1 : count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StRun;
      pc_q         <= RESET_PC;
      misaligned_q <= 1'b0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      misaligned_q <= misaligned_d;
      count_q      <= count_d;
    end
  end

`ifdef BRANCH_DELAY_SLOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end
`endif

  if_id_register #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_if_id (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (capture),
    .flush_i    (flush),
    .ready_i    (id_ready),
    .instr_i    (imem_instruction),
    .pc_i       (pc_q),
    .pc_plus4_i (pc_plus4),
    .valid_o    (id_valid),
    .instr_o    (id_instruction),
    .pc_o       (id_pc),
    .pc_plus4_o (id_pc_plus4)
  );

  assign imem_address     = pc_q;
  assign fetch_misaligned = misaligned_q;
  assign fetch_count      = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit (both BRANCH_DELAY_SLOT_EN builds).
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        id_ready;
  logic [31:0] imem_address, imem_instruction;
  logic        id_valid;
  logic [31:0] id_instruction, id_pc, id_pc_plus4;
  logic        fetch_misaligned;
  logic [15:0] fetch_count;

  logic [31:0] s_imem_address, s_imem_instruction;
  logic        s_id_valid;
  logic [31:0] s_id_instruction, s_id_pc, s_id_pc_plus4;
  logic        s_fetch_misaligned;
  logic [3:0]  s_fetch_count;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] imem_word(input logic [31:0] a);
    case (a)
      32'h0:   imem_word = 32'h2008_0005;
      32'h4:   imem_word = 32'h2009_0003;
      32'h8:   imem_word = 32'h0109_5020;
      default: imem_word = 32'hC000_0000 | a;
    endcase
  endfunction

  assign imem_instruction   = imem_word(imem_address);
  assign s_imem_instruction = imem_word(s_imem_address);

  instruction_fetch_unit dut (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .halt_req         (halt_req),
    .id_ready         (id_ready),
    .id_valid         (id_valid),
    .id_instruction   (id_instruction),
    .id_pc            (id_pc),
    .id_pc_plus4      (id_pc_plus4),
    .fetch_misaligned (fetch_misaligned),
    .fetch_count      (fetch_count)
  );

  instruction_fetch_unit #(
    .COUNT_WIDTH(4)
  ) dut_sat (
    .clk              (clk),
    .reset            (reset),
    .imem_address     (s_imem_address),
    .imem_instruction (s_imem_instruction),
    .redirect_valid   (1'b0),
    .redirect_pc      (32'h0),
    .halt_req         (1'b0),
    .id_ready         (1'b1),
    .id_valid         (s_id_valid),
    .id_instruction   (s_id_instruction),
    .id_pc            (s_id_pc),
    .id_pc_plus4      (s_id_pc_plus4),
    .fetch_misaligned (s_fetch_misaligned),
    .fetch_count      (s_fetch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; id_ready = 1'b1;
    step(); step();
    checks++; if (id_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", id_valid); else passed++;
    checks++; if (imem_address !== 32'h0) $display("FAIL rst_pc: got %h want 0", imem_address); else passed++;
    checks++; if (id_instruction !== 32'h0) $display("FAIL rst_instr: got %h want 0", id_instruction); else passed++;
    checks++; if (id_pc_plus4 !== 32'h0) $display("FAIL rst_pc4: got %h want 0", id_pc_plus4); else passed++;
    checks++; if (fetch_count !== 16'h0) $display("FAIL rst_count: got %h want 0", fetch_count); else passed++;
    checks++; if (fetch_misaligned !== 1'b0) $display("FAIL rst_mis: got %b want 0", fetch_misaligned); else passed++;
    reset = 1'b0;
  endtask

  task automatic test_sequence();
    checks++; if (id_valid !== 1'b0) $display("FAIL seq_first_valid: got %b want 0", id_valid); else passed++;
    step();
    checks++; if (id_pc !== 32'h0 || id_instruction !== 32'h2008_0005 || id_valid !== 1'b1)
      $display("FAIL seq0: got pc %h instr %h v %b want 0 20080005 1", id_pc, id_instruction, id_valid);
    else passed++;
    step();
    checks++; if (id_pc !== 32'h4 || id_instruction !== 32'h2009_0003)
      $display("FAIL seq1: got pc %h instr %h want 4 20090003", id_pc, id_instruction); else passed++;
    step();
    checks++; if (id_pc !== 32'h8 || id_instruction !== 32'h0109_5020 || id_pc_plus4 !== 32'hC)
      $display("FAIL seq2: got pc %h instr %h p4 %h want 8 01095020 c", id_pc, id_instruction, id_pc_plus4);
    else passed++;
    checks++; if (fetch_count !== 16'd3) $display("FAIL seq_count: got %0d want 3", fetch_count); else passed++;
  endtask

  task automatic test_stall();
    id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (id_pc !== 32'h8 || id_instruction !== 32'h0109_5020 || id_valid !== 1'b1 || imem_address !== 32'hC)
        $display("FAIL stall_hold: got pc %h instr %h v %b addr %h want 8 01095020 1 c", id_pc, id_instruction, id_valid, imem_address);
      else passed++;
    end
    checks++; if (fetch_count !== 16'd3) $display("FAIL stall_count: got %0d want 3", fetch_count); else passed++;
    id_ready = 1'b1;
    step();
    checks++; if (id_pc !== 32'hC || imem_address !== 32'h10 || fetch_count !== 16'd4)
      $display("FAIL stall_release: got pc %h addr %h cnt %0d want c 10 4", id_pc, imem_address, fetch_count);
    else passed++;
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
`ifdef BRANCH_DELAY_SLOT_EN
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h10 || imem_address !== 32'h40)
      $display("FAIL redir_slot: got v %b pc %h addr %h want 1 10 40", id_valid, id_pc, imem_address);
    else passed++;
`else
    checks++; if (id_valid !== 1'b0 || imem_address !== 32'h40)
      $display("FAIL redir_bubble: got v %b addr %h want 0 40", id_valid, imem_address);
    else passed++;
`endif
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_pc_plus4 !== 32'h44)
      $display("FAIL redir_target: got v %b pc %h p4 %h want 1 40 44", id_valid, id_pc, id_pc_plus4);
    else passed++;
  endtask

  task automatic test_stalled_redirect();
    id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h80;
    step();
`ifdef BRANCH_DELAY_SLOT_EN
    checks++; if (id_pc !== 32'h40 || id_valid !== 1'b1 || imem_address !== 32'h44)
      $display("FAIL sredir_pend: got pc %h v %b addr %h want 40 1 44", id_pc, id_valid, imem_address);
    else passed++;
    redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    checks++; if (id_pc !== 32'h40 || imem_address !== 32'h44)
      $display("FAIL sredir_ignore: got pc %h addr %h want 40 44", id_pc, imem_address);
    else passed++;
    id_ready = 1'b1;
    step();
    checks++; if (id_pc !== 32'h44 || id_valid !== 1'b1 || imem_address !== 32'h80)
      $display("FAIL sredir_slot: got pc %h v %b addr %h want 44 1 80", id_pc, id_valid, imem_address);
    else passed++;
`else
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_address !== 32'h80)
      $display("FAIL sredir_flush: got v %b addr %h want 0 80", id_valid, imem_address);
    else passed++;
    id_ready = 1'b1;
`endif
    step();
    checks++; if (id_pc !== 32'h80 || id_valid !== 1'b1 || imem_address !== 32'h84)
      $display("FAIL sredir_target: got pc %h v %b addr %h want 80 1 84", id_pc, id_valid, imem_address);
    else passed++;
  endtask

  task automatic test_misaligned();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    checks++; if (imem_address !== 32'h40 || fetch_misaligned !== 1'b1)
      $display("FAIL mis_addr: got addr %h mis %b want 40 1", imem_address, fetch_misaligned);
    else passed++;
    step();
    checks++; if (id_pc !== 32'h40 || id_pc_plus4 !== 32'h44)
      $display("FAIL mis_pc: got pc %h p4 %h want 40 44", id_pc, id_pc_plus4); else passed++;
    checks++; if (fetch_misaligned !== 1'b1) $display("FAIL mis_sticky: got %b want 1", fetch_misaligned); else passed++;
  endtask

  task automatic test_halt();
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h100;
    step();
    halt_req = 1'b0; redirect_valid = 1'b0; id_ready = 1'b0;
    checks++; if (id_pc !== 32'h44 || id_valid !== 1'b1 || imem_address !== 32'h48)
      $display("FAIL halt_enter: got pc %h v %b addr %h want 44 1 48", id_pc, id_valid, imem_address);
    else passed++;
    step(); step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h44 || imem_address !== 32'h48)
      $display("FAIL halt_hold: got v %b pc %h addr %h want 1 44 48", id_valid, id_pc, imem_address);
    else passed++;
    id_ready = 1'b1;
    step();
    checks++; if (id_valid !== 1'b0) $display("FAIL halt_drain: got %b want 0", id_valid); else passed++;
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    step(); step();
    redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || imem_address !== 32'h48)
      $display("FAIL halt_frozen: got v %b addr %h want 0 48", id_valid, imem_address);
    else passed++;
    checks++; if (fetch_misaligned !== 1'b1) $display("FAIL halt_mis: got %b want 1", fetch_misaligned); else passed++;
  endtask

  task automatic test_reset_from_halt();
    reset = 1'b1;
    step();
    checks++; if (imem_address !== 32'h0 || id_valid !== 1'b0 || fetch_misaligned !== 1'b0 || fetch_count !== 16'h0)
      $display("FAIL hrst: got addr %h v %b mis %b cnt %0d want 0 0 0 0", imem_address, id_valid, fetch_misaligned, fetch_count);
    else passed++;
    reset = 1'b0;
    step();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instruction !== 32'h2008_0005)
      $display("FAIL hrst_run: got v %b pc %h instr %h want 1 0 20080005", id_valid, id_pc, id_instruction);
    else passed++;
  endtask

  task automatic test_saturation();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 14; i++) step();
    checks++; if (s_fetch_count !== 4'hE) $display("FAIL sat_14: got %h want e", s_fetch_count); else passed++;
    step();
    checks++; if (s_fetch_count !== 4'hF) $display("FAIL sat_15: got %h want f", s_fetch_count); else passed++;
    for (int i = 0; i < 5; i++) step();
    checks++; if (s_fetch_count !== 4'hF) $display("FAIL sat_20: got %h want f", s_fetch_count); else passed++;
    checks++; if (s_id_pc !== 32'h4C) $display("FAIL sat_pc: got %h want 4c", s_id_pc); else passed++;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_stall();
    test_redirect();
    test_stalled_redirect();
    test_misaligned();
    test_halt();
    test_reset_from_halt();
    test_saturation();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
